// File: rtl/ldpc_out_pack.sv
// ldpc_out_pack: packs the LDPC decoder's serial hard-decision bits into bytes, framed by code rate.
// Latency: byte_out/byte_vld one cycle after the 8th bit of a byte is sampled; frm_err one cycle after a mid-frame sync_in drop.
// Backpressure: none; sync_in is a free-running valid strobe. Define LDPC_PACK_LSB_FIRST_EN for LSB-first packing.
module ldpc_out_pack #(
    parameter int INFO_R12 = 4608,
    parameter int INFO_R34 = 6912,
    parameter int CNT_W    = 13
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rate,
    input  logic       bit_in,
    input  logic       sync_in,
    input  logic [4:0] num_iter,
    output logic [7:0] byte_out,
    output logic       byte_vld,
    output logic       frm_start,
    output logic       frm_end,
    output logic       frm_err,
    output logic [4:0] frm_iter
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Index of the last information bit of a frame for each rate.
    localparam logic [CNT_W-1:0] LAST_R12 = CNT_W'(INFO_R12 - 1);
    localparam logic [CNT_W-1:0] LAST_R34 = CNT_W'(INFO_R34 - 1);
    localparam logic [CNT_W-1:0] LAST_OF_BYTE0 = CNT_W'(7);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       sr_q, sr_d;
    logic             frm_rate_q, frm_rate_d;
    logic [4:0]       frm_iter_q, frm_iter_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             byte_vld_q, byte_vld_d;
    logic             frm_start_q, frm_start_d;
    logic             frm_end_q, frm_end_d;
    logic             frm_err_q, frm_err_d;
    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] last_idx;

    // Next-state: frame delimiting, bit shifting, byte emission and truncation detection.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        frm_rate_d  = frm_rate_q;
        frm_iter_d  = frm_iter_q;
        byte_out_d  = byte_out_q;
        byte_vld_d  = 1'b0;
        frm_start_d = 1'b0;
        frm_end_d   = 1'b0;
        frm_err_d   = 1'b0;
        pos         = bit_cnt_q;
        last_idx    = LAST_R12;

        if (sync_in) begin
            // A bit arriving while idle opens a new frame and resamples rate/iteration count.
            if (state_q == IDLE) begin
                frm_rate_d = rate;
                frm_iter_d = num_iter;
                pos        = '0;
            end
            last_idx = frm_rate_d ? LAST_R34 : LAST_R12;

`ifdef LDPC_PACK_LSB_FIRST_EN
            sr_d = {bit_in, sr_q[7:1]};
`else
            sr_d = {sr_q[6:0], bit_in};
`endif

            if (pos[2:0] == 3'd7) begin
                byte_vld_d  = 1'b1;
                byte_out_d  = sr_d;
                frm_start_d = (pos == LAST_OF_BYTE0);
                frm_end_d   = (pos == last_idx);
            end

            // Completion returns to IDLE so a still-high sync_in starts the next frame without a bubble.
            if (pos == last_idx) begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                bit_cnt_d = pos + 1'b1;
                state_d   = RECV;
            end
        end else if (state_q == RECV) begin
            // Early sync drop: the partial byte is simply abandoned.
            frm_err_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            frm_rate_q  <= 1'b0;
            frm_iter_q  <= '0;
            byte_out_q  <= '0;
            byte_vld_q  <= 1'b0;
            frm_start_q <= 1'b0;
            frm_end_q   <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            frm_rate_q  <= frm_rate_d;
            frm_iter_q  <= frm_iter_d;
            byte_out_q  <= byte_out_d;
            byte_vld_q  <= byte_vld_d;
            frm_start_q <= frm_start_d;
            frm_end_q   <= frm_end_d;
            frm_err_q   <= frm_err_d;
        end
    end

    assign byte_out  = byte_out_q;
    assign byte_vld  = byte_vld_q;
    assign frm_start = frm_start_q;
    assign frm_end   = frm_end_q;
    assign frm_err   = frm_err_q;
    assign frm_iter  = frm_iter_q;

endmodule

// File: tb/tb_ldpc_out_pack.sv
// Bench for ldpc_out_pack: scenario bit streams are built into arrays, a frame-level model derives
// the expected output of every cycle, and the run compares the DUT against it cycle by cycle.
// Literal expectations (byte counts, pattern bytes, iteration values) pin the model itself.
module tb_ldpc_out_pack;

    localparam int MAXL = 12000;

    logic       clk;
    logic       reset_n;
    logic       rate;
    logic       bit_in;
    logic       sync_in;
    logic [4:0] num_iter;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic       frm_start;
    logic       frm_end;
    logic       frm_err;
    logic [4:0] frm_iter;

    ldpc_out_pack dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rate      (rate),
        .bit_in    (bit_in),
        .sync_in   (sync_in),
        .num_iter  (num_iter),
        .byte_out  (byte_out),
        .byte_vld  (byte_vld),
        .frm_start (frm_start),
        .frm_end   (frm_end),
        .frm_err   (frm_err),
        .frm_iter  (frm_iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scenario stimulus, one entry per cycle.
    logic       s_sync [MAXL];
    logic       s_bit  [MAXL];
    logic       s_rate [MAXL];
    logic [4:0] s_iter [MAXL];

    // Expected outputs observed after edge t, stored at index t+1.
    logic       e_vld   [MAXL+1];
    logic       e_start [MAXL+1];
    logic       e_end   [MAXL+1];
    logic       e_err   [MAXL+1];
    logic [7:0] e_byte  [MAXL+1];
    logic [4:0] e_iter  [MAXL+1];

    logic [4:0] m_iter;
    int         checks;
    int         errors;
    int         n_vld, n_start, n_end, n_err, m_vld;
    logic [7:0] first_byte, last_byte;

    task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Frame-level reference: bit index within frame decides byte boundaries, markers and errors.
    task automatic build_model(input int len);
        int pos;
        int n;
        logic [7:0] acc;
        pos = -1;
        n   = 0;
        acc = '0;
        m_vld = 0;
        for (int t = 0; t < len; t++) begin
            e_vld[t+1]   = 1'b0;
            e_start[t+1] = 1'b0;
            e_end[t+1]   = 1'b0;
            e_err[t+1]   = 1'b0;
            e_byte[t+1]  = '0;
            if (s_sync[t]) begin
                if (pos < 0) begin
                    n      = s_rate[t] ? 6912 : 4608;
                    m_iter = s_iter[t];
                    pos    = 0;
                end
`ifdef LDPC_PACK_LSB_FIRST_EN
                acc[pos % 8] = s_bit[t];
`else
                acc[7 - (pos % 8)] = s_bit[t];
`endif
                if (pos % 8 == 7) begin
                    e_vld[t+1]   = 1'b1;
                    e_byte[t+1]  = acc;
                    e_start[t+1] = (pos == 7);
                    e_end[t+1]   = (pos == n - 1);
                    m_vld++;
                end
                pos++;
                if (pos == n) pos = -1;
            end else if (pos >= 0) begin
                e_err[t+1] = 1'b1;
                pos = -1;
            end
            e_iter[t+1] = m_iter;
        end
    endtask

    // Drives the scenario and compares every cycle against the model.
    task automatic run_seg(input int len);
        n_vld = 0; n_start = 0; n_end = 0; n_err = 0;
        first_byte = 8'h00; last_byte = 8'h00;
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            sync_in  = s_sync[t];
            bit_in   = s_bit[t];
            rate     = s_rate[t];
            num_iter = s_iter[t];
            @(posedge clk);
            #1;
            chk("byte_vld",  t + 1, {7'd0, byte_vld},  {7'd0, e_vld[t+1]});
            chk("frm_start", t + 1, {7'd0, frm_start}, {7'd0, e_start[t+1]});
            chk("frm_end",   t + 1, {7'd0, frm_end},   {7'd0, e_end[t+1]});
            chk("frm_err",   t + 1, {7'd0, frm_err},   {7'd0, e_err[t+1]});
            chk("frm_iter",  t + 1, {3'd0, frm_iter},  {3'd0, e_iter[t+1]});
            if (e_vld[t+1]) chk("byte_out", t + 1, byte_out, e_byte[t+1]);
            if (byte_vld) begin
                if (n_vld == 0) first_byte = byte_out;
                last_byte = byte_out;
                n_vld++;
            end
            if (frm_start) n_start++;
            if (frm_end)   n_end++;
            if (frm_err)   n_err++;
        end
    endtask

    task automatic idle_fill(input int from, input int to);
        for (int t = from; t < to; t++) begin
            s_sync[t] = 1'b0;
            s_bit[t]  = 1'($urandom);
            s_rate[t] = 1'($urandom);
            s_iter[t] = 5'($urandom);
        end
    endtask

    task automatic rand_bits(input int from, input int to, input logic r, input logic [4:0] it);
        for (int t = from; t < to; t++) begin
            s_sync[t] = 1'b1;
            s_bit[t]  = 1'($urandom);
            s_rate[t] = (t == from) ? r : 1'($urandom);
            s_iter[t] = (t == from) ? it : 5'($urandom);
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        sync_in  = 1'b0;
        bit_in   = 1'b0;
        rate     = 1'b0;
        num_iter = '0;
        m_iter   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_byte_out"}, 0, byte_out, 8'h00);
        chk({name, "_ctl"}, 0, {4'd0, byte_vld, frm_start, frm_end, frm_err}, 8'h00);
        chk({name, "_frm_iter"}, 0, {3'd0, frm_iter}, 8'h00);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] kb;
        checks = 0;
        errors = 0;
        reset_n  = 1'b0;
        sync_in  = 1'b0;
        bit_in   = 1'b0;
        rate     = 1'b0;
        num_iter = '0;
        m_iter   = '0;
        #1;
        chk_all_zero("reset");
        do_reset();

        // Scenario 1: rate 1/2, repeated 1,0,1,1,0,0,0,1 pattern.
        pat = 8'b1011_0001;
        for (int t = 0; t < 4608; t++) begin
            s_sync[t] = 1'b1;
            s_bit[t]  = pat[7 - (t % 8)];
            s_rate[t] = 1'b0;
            s_iter[t] = (t == 0) ? 5'd7 : 5'($urandom);
        end
        idle_fill(4608, 4612);
        build_model(4612);
        chk("s1_model_bytes", 0, 8'(m_vld / 8), 8'(576 / 8));
        run_seg(4612);
        chk("s1_bytes_hi", 0, 8'(n_vld >> 8), 8'(576 >> 8));
        chk("s1_bytes_lo", 0, 8'(n_vld), 8'(576));
`ifdef LDPC_PACK_LSB_FIRST_EN
        chk("s1_first_byte", 0, first_byte, 8'h8D);
        chk("s1_last_byte", 0, last_byte, 8'h8D);
`else
        chk("s1_first_byte", 0, first_byte, 8'hB1);
        chk("s1_last_byte", 0, last_byte, 8'hB1);
`endif
        chk("s1_starts_ends", 0, 8'({n_start[3:0], n_end[3:0]}), 8'h11);
        chk("s1_errs", 0, 8'(n_err), 8'd0);
        chk("s1_iter", 0, {3'd0, frm_iter}, 8'd7);

        // Scenario 2: rate 3/4, incrementing bytes, rate/iter wiggled mid-frame.
        for (int t = 0; t < 6912; t++) begin
            kb = 8'(t / 8);
            s_sync[t] = 1'b1;
            s_bit[t]  = kb[7 - (t % 8)];
            s_rate[t] = (t == 0) ? 1'b1 : 1'($urandom);
            s_iter[t] = (t == 0) ? 5'd20 : 5'($urandom);
        end
        idle_fill(6912, 6916);
        build_model(6916);
        run_seg(6916);
        chk("s2_bytes_hi", 0, 8'(n_vld >> 8), 8'(864 >> 8));
        chk("s2_bytes_lo", 0, 8'(n_vld), 8'(864));
        chk("s2_ends", 0, 8'(n_end), 8'd1);
`ifdef LDPC_PACK_LSB_FIRST_EN
        chk("s2_last_byte", 0, last_byte, 8'hFA);
`else
        chk("s2_first_byte", 0, first_byte, 8'h00);
        chk("s2_last_byte", 0, last_byte, 8'h5F);
`endif
        chk("s2_iter", 0, {3'd0, frm_iter}, 8'd20);

        // Scenario 3: back-to-back frames, rate 0 / iter 3 then rate 1 / iter 12.
        rand_bits(0, 4608, 1'b0, 5'd3);
        rand_bits(4608, 11520, 1'b1, 5'd12);
        idle_fill(11520, 11523);
        build_model(11523);
        run_seg(11523);
        chk("s3_starts", 0, 8'(n_start), 8'd2);
        chk("s3_ends", 0, 8'(n_end), 8'd2);
        chk("s3_bytes_lo", 0, 8'(n_vld), 8'(1440));
        chk("s3_iter", 0, {3'd0, frm_iter}, 8'd12);

        // Scenario 4: truncation after 1001 bits, then a clean frame.
        rand_bits(0, 1001, 1'b0, 5'd9);
        idle_fill(1001, 1004);
        build_model(1004);
        run_seg(1004);
        chk("s4_bytes", 0, 8'(n_vld), 8'd125);
        chk("s4_errs", 0, 8'(n_err), 8'd1);
        chk("s4_ends", 0, 8'(n_end), 8'd0);
        rand_bits(0, 4608, 1'b0, 5'd5);
        idle_fill(4608, 4610);
        build_model(4610);
        run_seg(4610);
        chk("s4b_bytes_lo", 0, 8'(n_vld), 8'(576));
        chk("s4b_ends", 0, 8'(n_end), 8'd1);

        // Scenario 5: asynchronous reset after 300 bits, then a clean frame.
        rand_bits(0, 300, 1'b0, 5'd17);
        build_model(300);
        run_seg(300);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        sync_in = 1'b0;
        m_iter  = '0;
        @(posedge clk);
        #1;
        chk_all_zero("reset_hold");
        @(negedge clk);
        reset_n = 1'b1;
        rand_bits(0, 4608, 1'b0, 5'd30);
        idle_fill(4608, 4610);
        build_model(4610);
        run_seg(4610);
        chk("s5_bytes_hi", 0, 8'(n_vld >> 8), 8'(576 >> 8));
        chk("s5_bytes_lo", 0, 8'(n_vld), 8'(576));
        chk("s5_errs", 0, 8'(n_err), 8'd0);

        // Scenario 6: random sync gaps with frequent, then rare, drops.
        for (int t = 0; t < 6000; t++) begin
            s_sync[t] = ($urandom_range(0, 49) != 0);
            s_bit[t]  = 1'($urandom);
            s_rate[t] = 1'($urandom);
            s_iter[t] = 5'($urandom);
        end
        idle_fill(6000, 6002);
        build_model(6002);
        run_seg(6002);
        for (int t = 0; t < 10000; t++) begin
            s_sync[t] = ($urandom_range(0, 3999) != 0);
            s_bit[t]  = 1'($urandom);
            s_rate[t] = 1'($urandom);
            s_iter[t] = 5'($urandom);
        end
        idle_fill(10000, 10002);
        build_model(10002);
        run_seg(10002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldpc_out_pack.md
Name: ldpc_out_pack

Overview:
Sink-side packer for the LDPC decoder's serial output. It accepts the decoder's hard-decision bit stream (data_out/sync_out), delimits frames by code rate, and packs information bits into bytes with frame start/end markers. The decoder's iteration count is captured per frame. Sits directly after the LDPC decoder, feeding the downstream byte-oriented deinterleaver/RS path.

Parameters:
INFO_R12, 4608, information bits per frame for rate=0 (1/2).
INFO_R34, 6912, information bits per frame for rate=1 (3/4).
CNT_W, 13, bit-counter width; must hold INFO_R34-1.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
rate  input  1  code rate, 0=1/2, 1=3/4; sampled only at frame start.
bit_in  input  1  decoded bit (decoder data_out).
sync_in  input  1  bit valid (decoder sync_out); high for every valid bit.
num_iter  input  5  decoder iteration count; sampled at frame start.
byte_out  output  8  packed byte.
byte_vld  output  1  byte_out valid, single-cycle pulse per byte.
frm_start  output  1  coincident with byte_vld of the first byte of a frame.
frm_end  output  1  coincident with byte_vld of the last byte of a frame.
frm_err  output  1  one-cycle pulse: frame truncated (sync_in dropped early).
frm_iter  output  5  num_iter captured for the current frame.

Behaviour:
- Reset: all outputs 0; FSM IDLE; bit counter 0; shift register 0; frm_rate 0.
- FSM states: IDLE, RECV.
- IDLE: on a cycle with sync_in=1 -> capture bit_in as bit 0, latch rate into frm_rate, latch num_iter into frm_iter, set bit_cnt=1, go RECV.
- RECV, sync_in=1: shift bit_in in; bit_cnt++.
- Bit order: first received bit of each byte goes to byte_out[7] (MSB-first).
- Byte emit: the bit accepted at an edge where bit_cnt[2:0] becomes 0 (the 8th bit of a byte) produces byte_out/byte_vld=1 on the next cycle. Latency: 1 cycle after the 8th bit's sampling edge.
- frm_start asserts with the byte whose bit indices are 0..7; frm_end asserts with the byte containing bit N-1, where N=INFO_R12 or INFO_R34 per frm_rate.
- Frame completion: when bit N-1 is accepted, bit_cnt clears to 0. If sync_in is still high on the next cycle, that bit starts a new frame exactly as from IDLE (rate and num_iter resampled, back-to-back frames, no bubble). Otherwise go IDLE.
- Truncation: in RECV with sync_in=0 and 0<bit_cnt<N -> pulse frm_err next cycle, discard partial byte (no byte_vld), clear counter, go IDLE. Bytes already emitted for that frame remain valid; frm_end is never issued for a truncated frame.
- rate and num_iter changes mid-frame are ignored.
- frm_iter holds its value until the next frame start.
- Async reset mid-frame: immediate return to reset state; no frm_err or frm_end is generated.
- N is a multiple of 8 for both rates, so a partial byte at frame end never occurs.

Optional Feature:
Macro LDPC_PACK_LSB_FIRST_EN. When defined, the first received bit of each byte goes to byte_out[0] (LSB-first). All timing and framing are unchanged. When undefined, packing is MSB-first as above.

Test Plan:
- Reset, then rate=0, num_iter=7, 4608 bits of pattern 1,0,1,1,0,0,0,1 repeated, sync_in continuous -> 576 byte_vld pulses, each 8'hB1; frm_start on the 1st, frm_end on the 576th; frm_iter=7; frm_err never set.
- rate=1, incrementing-byte bit pattern, 6912 bits -> 864 bytes 8'h00..8'hFF wrapping; frm_end on byte 864; rate toggled mid-frame has no effect.
- Two back-to-back frames (rate 0 then 1, num_iter 3 then 12) with sync_in held high for 4608+6912 cycles -> frm_end of frame 1 followed by frm_start of frame 2 with no gap bytes missing; frm_iter changes 3 -> 12 at the second frame start.
- rate=0, sync_in drops after 1001 bits -> 125 bytes emitted, frm_err pulses once, no frm_end, FSM in IDLE; next full frame packs correctly.
- reset_n asserted after 300 bits -> outputs 0 immediately, no frm_err; a following full frame produces exactly 576 correct bytes.
- With LDPC_PACK_LSB_FIRST_EN defined, the first scenario's pattern -> every byte is 8'h8D.
